// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// aes_pkg: shared AES-128 types, S-box table and round-function helpers.
// Rev 1.0
// ============================================================================
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_word_t;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } ctrl_state_e;

  // Forward S-box; entry 0 occupies the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_state_t sub_bytes(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte index is 4*col+row; row r rotates left by r columns.
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
    return o;
  endfunction

  function automatic aes_state_t mix_columns(input aes_state_t s);
    aes_state_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(4*c)   +: 8];
      a1 = s[8*(4*c+1) +: 8];
      a2 = s[8*(4*c+2) +: 8];
      a3 = s[8*(4*c+3) +: 8];
      o[8*(4*c)   +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[8*(4*c+1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[8*(4*c+2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[8*(4*c+3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_step.sv
`default_nettype none
// ============================================================================
// aes_key_step: one AES-128 key-schedule step (round key r-1 -> round key r).
// Rev 1.0
// ============================================================================
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_key
);

  aes_word_t w0, w1, w2, w3;
  aes_word_t rot_word, sub_word;
  aes_word_t n0, n1, n2, n3;

  assign w0 = i_key[31:0];
  assign w1 = i_key[63:32];
  assign w2 = i_key[95:64];
  assign w3 = i_key[127:96];

  // RotWord with byte 0 in the low lane: lane j takes byte j+1.
  assign rot_word = {w3[7:0], w3[31:8]};

  for (genvar j = 0; j < 4; j++) begin : g_sbox
    assign sub_word[8*j +: 8] = sbox(rot_word[8*j +: 8]);
  end

  assign n0 = w0 ^ sub_word ^ {24'h000000, i_rcon};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign o_key = {n3, n2, n1, n0};

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// aes_round_ctrl: iterative AES-128 encryption, one round per clock.
// Rev 1.0
// ============================================================================
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [KEY_W-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             busy,
  output logic [3:0]       round_o
);

  if (NR != AES_NR || KEY_W != 128) begin : g_param_check
    $error("aes_round_ctrl supports only NR=10 and KEY_W=128");
  end

  localparam logic [3:0] c_last_round = 4'(NR);

  ctrl_state_e fsm_q, fsm_d;
  aes_state_t  state_q, state_d;
  aes_state_t  key_q, key_d;
  logic [3:0]  round_q, round_d;

  logic [7:0]  rcon_byte;
  aes_state_t  round_key;
  aes_state_t  shifted;
  aes_state_t  round_out;

  assign rcon_byte = rcon(round_q);

  aes_key_step u_key_step (
    .i_key  (key_q),
    .i_rcon (rcon_byte),
    .o_key  (round_key)
  );

  assign shifted   = shift_rows(sub_bytes(state_q));
  assign round_out = ((round_q == c_last_round) ? shifted : mix_columns(shifted)) ^ round_key;

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    key_d     = key_q;
    round_d   = round_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    unique case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      ROUND: begin
        busy    = 1'b1;
        state_d = round_out;
        key_d   = round_key;
        if (round_q == c_last_round) begin
          round_d = 4'd0;
          fsm_d   = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase

    // Neither handshake may complete while held in reset or being flushed.
    in_ready  = in_ready & rst_n & ~flush;
    out_valid = out_valid & ~flush;

    if (out_valid && out_ready) fsm_d = IDLE;

    if (in_valid && in_ready) begin
      state_d = in_data ^ in_key;
      key_d   = in_key;
      round_d = 4'd1;
      fsm_d   = ROUND;
    end

    if (flush) begin
      fsm_d   = IDLE;
      state_d = '0;
      key_d   = '0;
      round_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  assign out_data = state_q;
  assign round_o  = round_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// Directed and randomized bench for aes_round_ctrl against an algebraic AES model.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, in_key, out_data;
  logic [3:0]   round_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .round_o   (round_o)
  );

  // ---------------- reference model (GF(2^8) arithmetic, byte arrays) -------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // Multiplicative inverse as x^254, then the affine transform.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq = x; inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] st [16];
    logic [7:0] tmp [16];
    logic [7:0] rk [176];
    logic [7:0] t [4];
    logic [7:0] u [4];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      rk[i] = key[8*i +: 8];
      st[i] = pt[8*i +: 8] ^ rk[i];
    end
    rc = 8'h01;
    for (int w = 4; w < 44; w++) begin
      for (int j = 0; j < 4; j++) t[j] = rk[4*(w-1)+j];
      if (w % 4 == 0) begin
        for (int j = 0; j < 4; j++) u[j] = sbox_ref(t[(j+1)%4]);
        for (int j = 0; j < 4; j++) t[j] = u[j];
        t[0] = t[0] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) rk[4*w+j] = rk[4*(w-4)+j] ^ t[j];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) tmp[i] = sbox_ref(st[i]);
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          st[4*c+rr] = tmp[4*((c+rr)%4)+rr];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[16*r+i];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[8*i +: 8] = st[i];
    return res;
  endfunction

  // FIPS hex strings list byte 0 first; the bus carries byte 0 in bits [7:0].
  function automatic logic [127:0] fips(input logic [127:0] h);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = h[127-8*i -: 8];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- checking helpers ----------------------------------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Returns one cycle after the input handshake (round 1 in progress).
  task automatic present(input logic [127:0] k, input logic [127:0] p, input string tag);
    int n;
    n = 0;
    in_key = k; in_data = p; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    check({tag, " accept"}, 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    in_key   = rnd128();
    in_data  = rnd128();
  endtask

  // Walks rounds 1..10 and returns in the first cycle out_valid is high.
  task automatic collect(input logic [127:0] exp, input string tag, input int pulse_round);
    int n;
    n = 1;
    while (!out_valid && n < 40) begin
      check({tag, " round"}, 128'(round_o), 128'(n));
      check({tag, " busy"}, 128'(busy), 128'd1);
      check({tag, " in_ready"}, 128'(in_ready), 128'd0);
      if (n == pulse_round) begin
        in_valid = 1'b1;
        in_key   = rnd128();
        in_data  = rnd128();
      end else begin
        in_valid = 1'b0;
      end
      step();
      n++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, 128'(n), 128'd11);
    check({tag, " data"}, out_data, exp);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    check({tag, " out_valid drop"}, 128'(out_valid), 128'd0);
    check({tag, " idle in_ready"}, 128'(in_ready), 128'd1);
    check({tag, " idle round"}, 128'(round_o), 128'd0);
  endtask

  // ---------------- stimulus ------------------------------------------------
  initial begin
    logic [127:0] c1_key, c1_pt, c1_ct, b_key, b_pt, b_ct, k, p;
    bit ok;

    c1_key = fips(128'h000102030405060708090a0b0c0d0e0f);
    c1_pt  = fips(128'h00112233445566778899aabbccddeeff);
    c1_ct  = fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    b_key  = fips(128'h2b7e151628aed2a6abf7158809cf4f3c);
    b_pt   = fips(128'h3243f6a8885a308d313198a2e0370734);
    b_ct   = fips(128'h3925841d02dc09fbdc118597196a0b32);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_key = '0;
    step();
    step();
    check("reset in_ready", 128'(in_ready), 128'd0);
    check("reset out_valid", 128'(out_valid), 128'd0);
    check("reset busy", 128'(busy), 128'd0);
    check("reset round", 128'(round_o), 128'd0);
    check("reset out_data", out_data, 128'd0);
    rst_n = 1'b1;
    step();
    check("post-reset in_ready", 128'(in_ready), 128'd1);

    out_ready = 1'b1;
    present(c1_key, c1_pt, "c1");
    collect(c1_ct, "c1", 0);
    drain("c1");

    present(b_key, b_pt, "fipsB");
    collect(b_ct, "fipsB", 0);
    drain("fipsB");

    // Backpressure then back-to-back
    out_ready = 1'b0;
    present(c1_key, c1_pt, "bp");
    collect(c1_ct, "bp", 0);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid !== 1'b1 || out_data !== c1_ct || in_ready !== 1'b0) ok = 1'b0;
    end
    check("bp stall stable", 128'(ok), 128'd1);
    out_ready = 1'b1; in_key = b_key; in_data = b_pt; in_valid = 1'b1;
    #1;
    check("b2b in_ready", 128'(in_ready), 128'd1);
    check("b2b out_valid", 128'(out_valid), 128'd1);
    check("b2b out_data", out_data, c1_ct);
    present(b_key, b_pt, "b2b");
    collect(b_ct, "b2b", 0);
    drain("b2b");

    // Input offered mid-block must be ignored
    k = rnd128(); p = rnd128();
    present(k, p, "busyin");
    collect(aes_ref(k, p), "busyin", 5);
    drain("busyin");

    // Flush at round 6
    k = rnd128(); p = rnd128();
    present(k, p, "flush");
    for (int i = 1; i < 6; i++) step();
    check("flush pre round", 128'(round_o), 128'd6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush round", 128'(round_o), 128'd0);
    check("flush busy", 128'(busy), 128'd0);
    check("flush out_data", out_data, 128'd0);
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (out_valid !== 1'b0) ok = 1'b0;
      step();
    end
    check("flush no output", 128'(ok), 128'd1);
    present(c1_key, c1_pt, "postflush");
    collect(c1_ct, "postflush", 0);
    drain("postflush");

    // Asynchronous reset between clock edges, mid-block
    present(c1_key, c1_pt, "arst");
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst busy", 128'(busy), 128'd0);
    check("arst round", 128'(round_o), 128'd0);
    check("arst out_valid", 128'(out_valid), 128'd0);
    check("arst out_data", out_data, 128'd0);
    check("arst in_ready", 128'(in_ready), 128'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("arst release in_ready", 128'(in_ready), 128'd1);
    check("arst release out_valid", 128'(out_valid), 128'd0);
    present(c1_key, c1_pt, "postrst");
    collect(c1_ct, "postrst", 0);
    drain("postrst");

    // Random blocks with random output stalls
    for (int it = 0; it < 5; it++) begin
      k = rnd128(); p = rnd128();
      present(k, p, "rand");
      collect(aes_ref(k, p), "rand", 0);
      out_ready = 1'b0;
      for (int s = 0; s < int'($urandom_range(0, 3)); s++) step();
      check("rand hold", out_data, aes_ref(k, p));
      drain("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES-128 encryption core controller. It sequences one full round per clock through the team's combinational SubBytes, ShiftRows and MixColumns blocks, plus an AddRoundKey XOR.
- Holds the 128-bit state register and a running round key, and expands the key on the fly.
- Provides valid/ready handshakes on input (plaintext+key) and output (ciphertext).
- Sits between the block-level stream interface and the round-function datapath.

Parameters:
- NR, 10, number of rounds. Fixed at 10 for AES-128; other values are unsupported and rejected by elaboration assertion.
- KEY_W, 128, key width. Only 128 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; returns to IDLE and discards the block in flight
- in_valid  in  1  plaintext+key valid
- in_ready  out  1  controller can accept a block
- in_data  in  128  plaintext; byte i at [8*i+:8], byte index = 4*col+row
- in_key  in  128  cipher key, same byte order
- out_valid  out  1  ciphertext valid
- out_ready  in  1  downstream accepts ciphertext
- out_data  out  128  ciphertext, same byte order
- busy  out  1  high in ROUND state
- round_o  out  4  current round number (0 in IDLE/DONE)

Behaviour:
- Reset: asynchronous and active-low.
  - State returns to IDLE.
  - state_q, key_q and out_data are cleared to 0.
  - round_o=0, out_valid=0, busy=0, in_ready=0 while rst_n low, in_ready=1 from first clock after release.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state_q <= in_data ^ in_key, key_q <= in_key, round <= 1, go to ROUND.
- ROUND (round r = 1..NR), each cycle:
  - next round key k_r = expand(key_q, rcon[r]). This is the standard AES-128 word recurrence: RotWord, SubWord, Rcon XOR on word 3, then chained XOR.
  - For r<NR: state_q <= MixColumns(ShiftRows(SubBytes(state_q))) ^ k_r.
  - For r==NR: MixColumns is bypassed.
  - key_q <= k_r, round <= r+1.
  - At r==NR go to DONE.
  - in_ready=0 throughout.
- DONE:
  - out_valid=1, out_data=state_q.
  - Data is held stable until out_valid&&out_ready.
  - On the output handshake: go to IDLE.
  - If in_valid is also high, accept the new block in the same cycle and go directly to ROUND (back-to-back). In this case in_ready = out_ready.
- Latency:
  - Input handshake at cycle T gives out_valid at T+11 (1 whitening cycle + 10 round cycles).
  - Throughput is one block per 11 cycles with out_ready held high.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36, indexed by r-1.
- Boundary conditions:
  - in_valid while ROUND: ignored, since in_ready=0. The source must hold its data per the valid/ready rule.
  - out_ready low in DONE: stall indefinitely with out_data stable.
  - flush has priority over all handshakes. Next cycle: IDLE, out_valid=0, round_o=0. State and key registers are zeroed.
  - Reset mid-ROUND: the block is lost and no output is produced.
  - round counter never exceeds NR; NR+1 is not reachable.
- Sampling: in_key is sampled only at acceptance. Changes during ROUND have no effect.

Decomposition:
- Package aes_pkg holds:
  - typedef aes_state_t (logic [127:0]) and aes_word_t (logic [31:0])
  - localparam AES_NR=10
  - rcon lookup function
  - sbox function or table shared with SubBytes
  - typedef enum ctrl_state_e {IDLE, ROUND, DONE}
- One natural sub-module: aes_key_step. It is combinational: key_q plus rcon byte in, next round key out, using 4 S-box lookups.
- The round datapath reuses the existing SubBytes, ShiftRows and MixColumns blocks unchanged.

Test Plan:
- FIPS-197 C.1 vector: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, out_ready=1 -> out_valid exactly 11 cycles after the input handshake, out_data 69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 B vector: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; round_o steps 1..10 over successive cycles.
- Backpressure and back-to-back: out_ready=0 for 20 cycles in DONE -> out_data stable and in_ready=0. Then raise out_ready with the second vector on in_valid -> both handshakes occur in one cycle, and the second ciphertext arrives 11 cycles later.
- Input during busy: pulse in_valid with different data at round 5 -> no acceptance; the first result is unchanged.
- flush asserted at round 6 -> IDLE next cycle, out_valid never asserts, round_o=0. A subsequent C.1 vector still produces the correct result.
- Async reset asserted mid-ROUND, off the clock edge -> outputs go to 0 immediately. After release, in_ready=1 and a fresh C.1 encryption is correct.
